// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: one outstanding memory request feeding a circular
// FIFO of {pc, instr} entries, flushed and restarted on redirect.
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {S_REQ, S_FULL, S_DISCARD} state_t;

    state_t        state_q;
    logic          imem_req_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   req_addr_q;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic          push, pop;

    assign out_valid = (count_q != '0);
    assign out_pc    = pc_mem[rd_ptr_q];
    assign out_instr = instr_mem[rd_ptr_q];
    assign imem_req  = imem_req_q;
    assign imem_addr = req_addr_q;

    assign pop  = out_valid && !stall && !redirect;
    assign push = (state_q == S_REQ) && imem_ack && !redirect && (count_q != FULL_CNT);

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Entry storage carries no reset; only count/pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= req_addr_q;
            instr_mem[wr_ptr_q] <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_REQ;
            imem_req_q <= 1'b1;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (redirect) begin
                        fetch_pc_q <= redirect_pc;
                        if (imem_ack) begin
                            req_addr_q <= redirect_pc;
                        end else begin
                            state_q <= S_DISCARD;
                        end
                    end else if (imem_ack) begin
                        fetch_pc_q <= req_addr_q + 32'd4;
                        req_addr_q <= req_addr_q + 32'd4;
                        if (count_d == FULL_CNT) begin
                            state_q    <= S_FULL;
                            imem_req_q <= 1'b0;
                        end
                    end
                end
                S_FULL: begin
                    if (redirect) begin
                        fetch_pc_q <= redirect_pc;
                        req_addr_q <= redirect_pc;
                        state_q    <= S_REQ;
                        imem_req_q <= 1'b1;
                    end else if (count_q != FULL_CNT) begin
                        req_addr_q <= fetch_pc_q;
                        state_q    <= S_REQ;
                        imem_req_q <= 1'b1;
                    end
                end
                S_DISCARD: begin
                    // The stale request stays on the bus until its ack arrives.
                    if (redirect) fetch_pc_q <= redirect_pc;
                    if (imem_ack) begin
                        req_addr_q <= redirect ? redirect_pc : fetch_pc_q;
                        state_q    <= S_REQ;
                    end
                end
                default: begin
                    state_q    <= S_REQ;
                    imem_req_q <= 1'b1;
                end
            endcase
        end
    end

endmodule
